// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage: opcodes, ALU/result codes,
// immediate formats and the ID/EX pipeline record.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J,
        IMM_U
    } imm_type_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [1:0]  result_src;
        logic [3:0]  alu_control;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic            illegal;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
    } id_ex_t;

    // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-to-execute bus: the ID/EX register contents seen by the execute stage.
interface decode_stage_if;
    import riscv_pkg::*;

    logic            valid_execute;
    logic            reg_write_execute;
    logic            mem_write_execute;
    logic            branch_execute;
    logic            jump_execute;
    logic            jalr_execute;
    logic            alu_src_a_execute;
    logic            alu_src_b_execute;
    logic [1:0]      result_src_execute;
    logic [3:0]      alu_control_execute;
    logic [2:0]      funct3_execute;
    logic [XLEN-1:0] rs1_data_execute;
    logic [XLEN-1:0] rs2_data_execute;
    logic [XLEN-1:0] imm_ext_execute;
    logic [4:0]      rs1_execute;
    logic [4:0]      rs2_execute;
    logic [4:0]      rd_execute;
    logic [XLEN-1:0] pc_execute;
    logic [XLEN-1:0] next_pc_execute;
    logic            illegal_execute;

    modport master (
        output valid_execute, reg_write_execute, mem_write_execute, branch_execute,
               jump_execute, jalr_execute, alu_src_a_execute, alu_src_b_execute,
               result_src_execute, alu_control_execute, funct3_execute,
               rs1_data_execute, rs2_data_execute, imm_ext_execute,
               rs1_execute, rs2_execute, rd_execute, pc_execute, next_pc_execute,
               illegal_execute
    );

    modport slave (
        input  valid_execute, reg_write_execute, mem_write_execute, branch_execute,
               jump_execute, jalr_execute, alu_src_a_execute, alu_src_b_execute,
               result_src_execute, alu_control_execute, funct3_execute,
               rs1_data_execute, rs2_data_execute, imm_ext_execute,
               rs1_execute, rs2_execute, rd_execute, pc_execute, next_pc_execute,
               illegal_execute
    );

endinterface

// File: rtl/register_file.sv
// 32x32 register file: two asynchronous read ports with write-through bypass,
// one synchronous write port. Contents are deliberately not reset.
module register_file
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] mem_q [32];
    logic [XLEN-1:0] mem_d [32];
    logic            write_active;

    assign write_active = we && (wr_addr != 5'd0);

    always_comb begin
        mem_d = mem_q;
        if (write_active) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // A same-cycle writeback to the register being read wins over the stored value
    always_comb begin
        rs1_data = mem_q[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (write_active && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end

        rs2_data = mem_q[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (write_active && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: IF/ID register, register file, main decoder
// with immediate generation, and the ID/EX register with stall/flush hooks.
module decode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instruction_fetch,
    input  logic [XLEN-1:0] pc_fetch,
    input  logic [XLEN-1:0] next_pc_fetch,
    input  logic            stall_decode,
    input  logic            flush_decode,
    input  logic            flush_execute,
    input  logic            reg_write_writeback,
    input  logic [4:0]      rd_writeback,
    input  logic [XLEN-1:0] result_writeback,
    decode_stage_if.master  ex
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic            valid_decode_q, valid_decode_d;

    always_comb begin
        instr_d        = instr_q;
        pc_d           = pc_q;
        next_pc_d      = next_pc_q;
        valid_decode_d = valid_decode_q;
        if (flush_decode) begin
            instr_d        = '0;
            pc_d           = '0;
            next_pc_d      = '0;
            valid_decode_d = 1'b0;
        end else if (!stall_decode) begin
            instr_d        = instruction_fetch;
            pc_d           = pc_fetch;
            next_pc_d      = next_pc_fetch;
            valid_decode_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q        <= '0;
            pc_q           <= '0;
            next_pc_q      <= '0;
            valid_decode_q <= 1'b0;
        end else begin
            instr_q        <= instr_d;
            pc_q           <= pc_d;
            next_pc_q      <= next_pc_d;
            valid_decode_q <= valid_decode_d;
        end
    end

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic            alt_bit;
    ctrl_t           ctrl;
    logic            illegal;
    imm_type_e       imm_type;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rs1_data, rs2_data;

    assign opcode  = instr_q[6:0];
    assign rd      = instr_q[11:7];
    assign funct3  = instr_q[14:12];
    assign rs1     = instr_q[19:15];
    assign rs2     = instr_q[24:20];
    assign alt_bit = instr_q[30];

    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        imm_type = IMM_NONE;
        case (opcode)
            OP_R: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = alu_decode(funct3, alt_bit);
            end
            OP_IMM: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = alu_decode(funct3, alt_bit && (funct3 == 3'b101));
                imm_type         = IMM_I;
            end
            OP_LOAD: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.result_src  = RES_MEM;
                ctrl.alu_control = ALU_ADD;
                imm_type         = IMM_I;
            end
            OP_STORE: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_ADD;
                imm_type         = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
                imm_type         = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write   = 1'b1;
                ctrl.jump        = 1'b1;
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.result_src  = RES_PC4;
                ctrl.alu_control = ALU_ADD;
                imm_type         = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write   = 1'b1;
                ctrl.jump        = 1'b1;
                ctrl.jalr        = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.result_src  = RES_PC4;
                ctrl.alu_control = ALU_ADD;
                imm_type         = IMM_I;
            end
            OP_LUI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_PASSB;
                imm_type         = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = 1'b1;
                ctrl.alu_control = ALU_ADD;
                imm_type         = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        // An empty IF/ID slot must never look like an instruction or a trap
        if (!valid_decode_q) begin
            ctrl    = '0;
            illegal = 1'b0;
        end
    end

    always_comb begin
        case (imm_type)
            IMM_I:   imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S:   imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B:   imm_ext = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                                instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_J:   imm_ext = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                                instr_q[20], instr_q[30:21], 1'b0};
            IMM_U:   imm_ext = {instr_q[31:12], 12'b0};
            default: imm_ext = '0;
        endcase
    end

    register_file u_register_file (
        .clk      (clk),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (reg_write_writeback),
        .wr_addr  (rd_writeback),
        .wr_data  (result_writeback)
    );

    id_ex_t id_ex_q, id_ex_d;

    always_comb begin
        id_ex_d = '0;
        if (!flush_execute) begin
            id_ex_d.valid    = valid_decode_q;
            id_ex_d.ctrl     = ctrl;
            id_ex_d.illegal  = illegal;
            id_ex_d.funct3   = funct3;
            id_ex_d.rs1_data = rs1_data;
            id_ex_d.rs2_data = rs2_data;
            id_ex_d.imm_ext  = imm_ext;
            id_ex_d.rs1      = rs1;
            id_ex_d.rs2      = rs2;
            id_ex_d.rd       = rd;
            id_ex_d.pc       = pc_q;
            id_ex_d.next_pc  = next_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex.valid_execute       = id_ex_q.valid;
    assign ex.reg_write_execute   = id_ex_q.ctrl.reg_write;
    assign ex.mem_write_execute   = id_ex_q.ctrl.mem_write;
    assign ex.branch_execute      = id_ex_q.ctrl.branch;
    assign ex.jump_execute        = id_ex_q.ctrl.jump;
    assign ex.jalr_execute        = id_ex_q.ctrl.jalr;
    assign ex.alu_src_a_execute   = id_ex_q.ctrl.alu_src_a;
    assign ex.alu_src_b_execute   = id_ex_q.ctrl.alu_src_b;
    assign ex.result_src_execute  = id_ex_q.ctrl.result_src;
    assign ex.alu_control_execute = id_ex_q.ctrl.alu_control;
    assign ex.funct3_execute      = id_ex_q.funct3;
    assign ex.rs1_data_execute    = id_ex_q.rs1_data;
    assign ex.rs2_data_execute    = id_ex_q.rs2_data;
    assign ex.imm_ext_execute     = id_ex_q.imm_ext;
    assign ex.rs1_execute         = id_ex_q.rs1;
    assign ex.rs2_execute         = id_ex_q.rs2;
    assign ex.rd_execute          = id_ex_q.rd;
    assign ex.pc_execute          = id_ex_q.pc;
    assign ex.next_pc_execute     = id_ex_q.next_pc;
    assign ex.illegal_execute     = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic
// compared against an instruction-level reference model.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_fetch, pc_fetch, next_pc_fetch;
    logic        stall_decode, flush_decode, flush_execute;
    logic        reg_write_writeback;
    logic [4:0]  rd_writeback;
    logic [31:0] result_writeback;

    decode_stage_if ex_if ();

    decode_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .instruction_fetch   (instruction_fetch),
        .pc_fetch            (pc_fetch),
        .next_pc_fetch       (next_pc_fetch),
        .stall_decode        (stall_decode),
        .flush_decode        (flush_decode),
        .flush_execute       (flush_execute),
        .reg_write_writeback (reg_write_writeback),
        .rd_writeback        (rd_writeback),
        .result_writeback    (result_writeback),
        .ex                  (ex_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_npc;

    logic [17:0] e_ctrl;
    logic [31:0] e_rs1d, e_rs2d, e_imm, e_pc, e_npc;
    logic [14:0] e_idx;

    logic [17:0] dut_ctrl;
    logic [14:0] dut_idx;

    assign dut_ctrl = {ex_if.valid_execute, ex_if.reg_write_execute, ex_if.mem_write_execute,
                       ex_if.branch_execute, ex_if.jump_execute, ex_if.jalr_execute,
                       ex_if.alu_src_a_execute, ex_if.alu_src_b_execute,
                       ex_if.result_src_execute, ex_if.alu_control_execute,
                       ex_if.funct3_execute, ex_if.illegal_execute};
    assign dut_idx  = {ex_if.rs1_execute, ex_if.rs2_execute, ex_if.rd_execute};

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, actual, expected, $time);
        end else begin
            checks_passed++;
        end
    endtask

    // Architectural view of one instruction: control word and immediate value
    function automatic void modelDecode(input logic [31:0] ins, output logic [17:0] ctrl,
                                        output logic [31:0] imm);
        logic [3:0] base [8];
        logic       rw, mw, br, jp, jr, sa, sb, ill;
        logic [1:0] res;
        logic [3:0] alu;
        logic [2:0] f3;
        logic [31:0] sgn;
        base = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
        f3   = ins[14:12];
        sgn  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        {rw, mw, br, jp, jr, sa, sb, ill} = 8'b0;
        res = 2'b00;
        alu = 4'h0;
        imm = 32'h0;
        case (ins[6:0])
            7'b0110011: begin
                rw = 1; alu = base[f3] + 4'(ins[30] && (f3 == 3'd0 || f3 == 3'd5));
            end
            7'b0010011: begin
                rw = 1; sb = 1; alu = base[f3] + 4'(ins[30] && f3 == 3'd5);
                imm = (sgn << 12) | 32'(ins[31:20]);
            end
            7'b0000011: begin
                rw = 1; sb = 1; res = 2'b01; imm = (sgn << 12) | 32'(ins[31:20]);
            end
            7'b0100011: begin
                mw = 1; sb = 1; imm = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
            end
            7'b1100011: begin
                br = 1; alu = 4'h1;
                imm = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'b1101111: begin
                rw = 1; jp = 1; sa = 1; sb = 1; res = 2'b10;
                imm = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'b1100111: begin
                rw = 1; jp = 1; jr = 1; sb = 1; res = 2'b10; imm = (sgn << 12) | 32'(ins[31:20]);
            end
            7'b0110111: begin
                rw = 1; sb = 1; alu = 4'hA; imm = ins & 32'hFFFF_F000;
            end
            7'b0010111: begin
                rw = 1; sa = 1; sb = 1; imm = ins & 32'hFFFF_F000;
            end
            default: ill = 1;
        endcase
        ctrl = {1'b1, rw, mw, br, jp, jr, sa, sb, res, alu, f3, ill};
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (reg_write_writeback && rd_writeback == idx) return result_writeback;
        return m_regs[idx];
    endfunction

    task automatic modelEdge();
        logic [17:0] c;
        logic [31:0] im;
        if (rst || flush_execute || !m_valid) begin
            e_ctrl = '0; e_rs1d = '0; e_rs2d = '0; e_imm = '0; e_pc = '0; e_npc = '0; e_idx = '0;
        end else begin
            modelDecode(m_instr, c, im);
            e_ctrl = c;
            e_imm  = im;
            e_rs1d = modelRead(m_instr[19:15]);
            e_rs2d = modelRead(m_instr[24:20]);
            e_idx  = {m_instr[19:15], m_instr[24:20], m_instr[11:7]};
            e_pc   = m_pc;
            e_npc  = m_npc;
        end
        if (rst || flush_decode) begin
            m_valid = 0; m_instr = '0; m_pc = '0; m_npc = '0;
        end else if (!stall_decode) begin
            m_valid = 1; m_instr = instruction_fetch; m_pc = pc_fetch; m_npc = next_pc_fetch;
        end
        if (reg_write_writeback && rd_writeback != 5'd0) m_regs[rd_writeback] = result_writeback;
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic st,
                                 input logic fd, input logic fe, input logic we,
                                 input logic [4:0] wrd, input logic [31:0] wd);
        logic [31:0] pc;
        pc = $urandom() & 32'hFFFF_FFFC;
        rst = r; instruction_fetch = instr; pc_fetch = pc; next_pc_fetch = pc + 32'd4;
        stall_decode = st; flush_decode = fd; flush_execute = fe;
        reg_write_writeback = we; rd_writeback = wrd; result_writeback = wd;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("ctrl", 32'(dut_ctrl), 32'(e_ctrl));
        checkOutput("rs1_data", ex_if.rs1_data_execute, e_rs1d);
        checkOutput("rs2_data", ex_if.rs2_data_execute, e_rs2d);
        checkOutput("imm_ext", ex_if.imm_ext_execute, e_imm);
        checkOutput("reg_idx", 32'(dut_idx), 32'(e_idx));
        checkOutput("pc", ex_if.pc_execute, e_pc);
        checkOutput("next_pc", ex_if.next_pc_execute, e_npc);
    endtask

    function automatic logic [31:0] randomInstr();
        logic [6:0]  ops [13];
        logic [31:0] r;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                7'b1100111, 7'b0110111, 7'b0010111, 7'h7F, 7'h00, 7'h0F, 7'h73};
        r = $urandom();
        r[6:0] = ops[$urandom_range(12)];
        return r;
    endfunction

    initial begin
        rst = 1; instruction_fetch = '0; pc_fetch = '0; next_pc_fetch = '0;
        stall_decode = 0; flush_decode = 0; flush_execute = 0;
        reg_write_writeback = 0; rd_writeback = '0; result_writeback = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 0; m_instr = '0; m_pc = '0; m_npc = '0;

        applyStimulus(1, NOP, 0, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(1, NOP, 0, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("rst_ctrl", 32'(dut_ctrl), 32'h0);
        checkOutput("rst_valid", 32'(ex_if.valid_execute), 32'h0);
        checkOutput("rst_rs1d", ex_if.rs1_data_execute, 32'h0);
        checkOutput("rst_imm", ex_if.imm_ext_execute, 32'h0);
        checkOutput("rst_pc", ex_if.pc_execute, 32'h0);
        checkOutput("rst_idx", 32'(dut_idx), 32'h0);

        for (int i = 1; i < 32; i++) applyStimulus(0, NOP, 0, 1, 1, 1, 5'(i), $urandom());

        applyStimulus(0, 32'h0050_0093, 0, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, NOP, 0, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("addi_rd", 32'(ex_if.rd_execute), 32'd1);
        checkOutput("addi_imm", ex_if.imm_ext_execute, 32'd5);
        checkOutput("addi_srcb", 32'(ex_if.alu_src_b_execute), 32'd1);
        checkOutput("addi_regw", 32'(ex_if.reg_write_execute), 32'd1);
        checkOutput("addi_alu", 32'(ex_if.alu_control_execute), 32'd0);

        applyStimulus(0, 32'h0010_8133, 0, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, NOP, 0, 0, 0, 1, 5'd1, 32'hDEAD_BEEF);
        checkOutput("bypass_rs1", ex_if.rs1_data_execute, 32'hDEAD_BEEF);
        checkOutput("bypass_rs2", ex_if.rs2_data_execute, 32'hDEAD_BEEF);

        applyStimulus(0, 32'h0000_01B3, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        applyStimulus(0, NOP, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        checkOutput("x0_rs1", ex_if.rs1_data_execute, 32'h0);
        checkOutput("x0_rs2", ex_if.rs2_data_execute, 32'h0);

        applyStimulus(0, 32'hFE00_0EE3, 0, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, NOP, 0, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("beq_imm", ex_if.imm_ext_execute, 32'hFFFF_FFFC);
        checkOutput("beq_branch", 32'(ex_if.branch_execute), 32'd1);
        checkOutput("beq_regw", 32'(ex_if.reg_write_execute), 32'd0);

        applyStimulus(0, 32'h0070_0293, 0, 0, 0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h00A0_0313, 1, 0, 1, 0, 5'd0, 32'h0);
            checkOutput("stall_bubble", 32'(ex_if.valid_execute), 32'd0);
        end
        applyStimulus(0, 32'h00A0_0313, 0, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("stall_held_rd", 32'(ex_if.rd_execute), 32'd5);
        checkOutput("stall_held_valid", 32'(ex_if.valid_execute), 32'd1);
        applyStimulus(0, 32'h00B0_0393, 0, 1, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, NOP, 0, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("flush_valid", 32'(ex_if.valid_execute), 32'd0);

        applyStimulus(0, 32'h0000_007F, 0, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, NOP, 0, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("illegal_flag", 32'(ex_if.illegal_execute), 32'd1);
        checkOutput("illegal_regw", 32'(ex_if.reg_write_execute), 32'd0);

        applyStimulus(0, 32'h0050_0093, 0, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(0, NOP, 1, 0, 0, 0, 5'd0, 32'h0);
        applyStimulus(1, NOP, 1, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("rst_stall_idex", 32'(dut_ctrl), 32'h0);
        applyStimulus(0, NOP, 0, 0, 0, 0, 5'd0, 32'h0);
        checkOutput("rst_stall_ifid", 32'(ex_if.valid_execute), 32'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(logic'($urandom_range(99) < 2), randomInstr(),
                          logic'($urandom_range(99) < 20), logic'($urandom_range(99) < 10),
                          logic'($urandom_range(99) < 10), logic'($urandom_range(1)),
                          5'($urandom_range(31)), $urandom());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
